// File: rtl/key_ui_pkg.sv
// Shared types, helpers and board-level timing defaults for the key input path.
package key_ui_pkg;

  // Auto-repeat FSM state encoding.
  typedef enum logic [1:0] {
    RPT_IDLE      = 2'd0,
    RPT_HOLD_WAIT = 2'd1,
    RPT_REPEATING = 2'd2
  } rpt_state_e;

  // Defaults for the 50 MHz board clock: ~21 ms debounce, 100 ms hold, 20 ms repeat.
  localparam int unsigned DEF_CNT_MAX       = 20'hF_FFFF;
  localparam int unsigned DEF_HOLD_CYCLES   = 24'd5_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES = 24'd1_000_000;

  // Raw pin level that means "not pressed" for the given polarity.
  function automatic logic released_level(input logic active_low);
    return active_low;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce counter, edge pulses, auto-repeat.
module key_debounce_ch
  import key_ui_pkg::*;
#(
  parameter int unsigned CNT_MAX       = DEF_CNT_MAX,
  parameter logic        ACTIVE_LOW    = 1'b0,
  parameter logic        REPEAT_EN     = 1'b0,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int unsigned TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             w_s;
  logic             w_accept;
  logic             w_rise;
  logic             w_fall;

  assign w_s      = r_sync[1] ^ ACTIVE_LOW;
  assign w_accept = (w_s != o_level) && (r_cnt == CNT_W'(CNT_MAX - 1));
  assign w_rise   = w_accept & w_s;
  assign w_fall   = w_accept & ~w_s;

  // Synchronise the pin, count stable mismatches, register level and edge pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync    <= {2{released_level(ACTIVE_LOW)}};
      r_cnt     <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_key};
      o_press   <= w_rise;
      o_release <= w_fall;
      if (w_s == o_level) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        o_level <= w_s;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  if (REPEAT_EN) begin : g_repeat
    rpt_state_e       r_state;
    rpt_state_e       w_state_nxt;
    logic [TMR_W-1:0] r_tmr;
    logic [TMR_W-1:0] w_tmr_nxt;
    logic             w_rpt_nxt;

    // Repeat FSM state, timer and registered repeat pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_state  <= RPT_IDLE;
        r_tmr    <= '0;
        o_repeat <= 1'b0;
      end else begin
        r_state  <= w_state_nxt;
        r_tmr    <= w_tmr_nxt;
        o_repeat <= w_rpt_nxt;
      end
    end

    // Next-state logic; a falling level overrides any repeat due in the same cycle.
    always_comb begin
      w_state_nxt = r_state;
      w_tmr_nxt   = r_tmr;
      w_rpt_nxt   = 1'b0;
      if (w_fall) begin
        w_state_nxt = RPT_IDLE;
        w_tmr_nxt   = '0;
      end else begin
        case (r_state)
          RPT_IDLE: begin
            if (w_rise) begin
              w_state_nxt = RPT_HOLD_WAIT;
              w_tmr_nxt   = '0;
            end
          end
          RPT_HOLD_WAIT: begin
            if (r_tmr == TMR_W'(HOLD_CYCLES - 1)) begin
              w_rpt_nxt   = 1'b1;
              w_state_nxt = RPT_REPEATING;
              w_tmr_nxt   = '0;
            end else begin
              w_tmr_nxt = r_tmr + TMR_W'(1);
            end
          end
          RPT_REPEATING: begin
            if (r_tmr == TMR_W'(REPEAT_CYCLES - 1)) begin
              w_rpt_nxt = 1'b1;
              w_tmr_nxt = '0;
            end else begin
              w_tmr_nxt = r_tmr + TMR_W'(1);
            end
          end
          default: begin
            w_state_nxt = RPT_IDLE;
            w_tmr_nxt   = '0;
          end
        endcase
      end
    end
  end else begin : g_no_repeat
    assign o_repeat = 1'b0;
  end

endmodule

// File: rtl/key_debounce_array.sv
// N_KEYS independent debounced key channels with press/release/repeat pulses.
module key_debounce_array
  import key_ui_pkg::*;
#(
  parameter int unsigned N_KEYS        = 4,
  parameter int unsigned CNT_MAX       = DEF_CNT_MAX,
  parameter logic        ACTIVE_LOW    = 1'b0,
  parameter logic        REPEAT_EN     = 1'b0,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat
);

  // One channel instance per key.
  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
    key_debounce_ch #(
      .CNT_MAX       (CNT_MAX),
      .ACTIVE_LOW    (ACTIVE_LOW),
      .REPEAT_EN     (REPEAT_EN),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_key     (key_in[gi]),
      .o_level   (key_level[gi]),
      .o_press   (key_press[gi]),
      .o_release (key_release[gi]),
      .o_repeat  (key_repeat[gi])
    );
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Directed bench: CNT_MAX=8, HOLD=20, REPEAT=5; second instance with ACTIVE_LOW=1.
module tb_key_debounce_array;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_in;
  logic [3:0] lvl, prs, rel, rpt;
  logic [3:0] key_in_al;
  logic [3:0] lvl_al, prs_al, rel_al, rpt_al;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  key_debounce_array #(
    .N_KEYS(4), .CNT_MAX(8), .ACTIVE_LOW(1'b0), .REPEAT_EN(1'b1),
    .HOLD_CYCLES(20), .REPEAT_CYCLES(5)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .key_in(key_in),
    .key_level(lvl), .key_press(prs), .key_release(rel), .key_repeat(rpt)
  );

  key_debounce_array #(
    .N_KEYS(4), .CNT_MAX(8), .ACTIVE_LOW(1'b1), .REPEAT_EN(1'b1),
    .HOLD_CYCLES(20), .REPEAT_CYCLES(5)
  ) u_dut_al (
    .i_clk(clk), .i_rst(rst), .key_in(key_in_al),
    .key_level(lvl_al), .key_press(prs_al), .key_release(rel_al), .key_repeat(rpt_al)
  );

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    key_in    = 4'h0;
    key_in_al = 4'hF;
    #2;
    n_cmp++;
    if ({lvl, prs, rel, rpt} !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_main got %h want 0000", {lvl, prs, rel, rpt});
    end
    n_cmp++;
    if ({lvl_al, prs_al, rel_al, rpt_al} !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_al got %h want 0000", {lvl_al, prs_al, rel_al, rpt_al});
    end
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({lvl_al, prs_al, rel_al, rpt_al} !== 16'h0) begin
      n_bad++;
      $display("FAIL idle_al got %h want 0000", {lvl_al, prs_al, rel_al, rpt_al});
    end
  endtask

  // t=1 is the capture edge; press at t=10, release pin after t=12 -> release at t=22.
  task automatic test_clean_press();
    logic [15:0] exp;
    key_in[0] = 1'b1;
    for (int t = 1; t <= 26; t++) begin
      step();
      exp = {((t >= 10 && t < 22) ? 4'b0001 : 4'b0000),
             ((t == 10) ? 4'b0001 : 4'b0000),
             ((t == 22) ? 4'b0001 : 4'b0000),
             4'b0000};
      n_cmp++;
      if ({lvl, prs, rel, rpt} !== exp) begin
        n_bad++;
        $display("FAIL clean_press t=%0d got %h want %h", t, {lvl, prs, rel, rpt}, exp);
      end
      if (t == 12) key_in[0] = 1'b0;
    end
  endtask

  // 7-cycle pulse rejected; 9-cycle pulse accepted at t=10 and released at t=19.
  task automatic test_glitch();
    logic [15:0] exp;
    key_in[1] = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      step();
      n_cmp++;
      if ({lvl, prs, rel, rpt} !== 16'h0) begin
        n_bad++;
        $display("FAIL glitch7 t=%0d got %h want 0000", t, {lvl, prs, rel, rpt});
      end
      if (t == 7) key_in[1] = 1'b0;
    end
    key_in[1] = 1'b1;
    for (int t = 1; t <= 24; t++) begin
      step();
      exp = {((t >= 10 && t < 19) ? 4'b0010 : 4'b0000),
             ((t == 10) ? 4'b0010 : 4'b0000),
             ((t == 19) ? 4'b0010 : 4'b0000),
             4'b0000};
      n_cmp++;
      if ({lvl, prs, rel, rpt} !== exp) begin
        n_bad++;
        $display("FAIL glitch9 t=%0d got %h want %h", t, {lvl, prs, rel, rpt}, exp);
      end
      if (t == 9) key_in[1] = 1'b0;
    end
  endtask

  // Press at t=10 (E); repeats E+20..E+55; pin dropped after t=58 -> release at t=68 (E+58).
  task automatic test_repeat();
    logic [15:0] exp;
    logic        due;
    key_in[2] = 1'b1;
    for (int t = 1; t <= 80; t++) begin
      step();
      due = (t >= 30) && (t <= 65) && (((t - 30) % 5) == 0);
      exp = {((t >= 10 && t < 68) ? 4'b0100 : 4'b0000),
             ((t == 10) ? 4'b0100 : 4'b0000),
             ((t == 68) ? 4'b0100 : 4'b0000),
             (due ? 4'b0100 : 4'b0000)};
      n_cmp++;
      if ({lvl, prs, rel, rpt} !== exp) begin
        n_bad++;
        $display("FAIL repeat t=%0d got %h want %h", t, {lvl, prs, rel, rpt}, exp);
      end
      if (t == 58) key_in[2] = 1'b0;
    end
  endtask

  // Release lands on the first due repeat (t=30); then a fresh press must repeat from E+20 again.
  task automatic test_release_wins();
    logic [15:0] exp;
    logic        due;
    key_in[1] = 1'b1;
    for (int t = 1; t <= 45; t++) begin
      step();
      exp = {((t >= 10 && t < 30) ? 4'b0010 : 4'b0000),
             ((t == 10) ? 4'b0010 : 4'b0000),
             ((t == 30) ? 4'b0010 : 4'b0000),
             4'b0000};
      n_cmp++;
      if ({lvl, prs, rel, rpt} !== exp) begin
        n_bad++;
        $display("FAIL release_wins t=%0d got %h want %h", t, {lvl, prs, rel, rpt}, exp);
      end
      if (t == 20) key_in[1] = 1'b0;
    end
    key_in[1] = 1'b1;
    for (int t = 1; t <= 45; t++) begin
      step();
      due = (t == 30) || (t == 35) || (t == 40);
      exp = {((t >= 10 && t < 41) ? 4'b0010 : 4'b0000),
             ((t == 10) ? 4'b0010 : 4'b0000),
             ((t == 41) ? 4'b0010 : 4'b0000),
             (due ? 4'b0010 : 4'b0000)};
      n_cmp++;
      if ({lvl, prs, rel, rpt} !== exp) begin
        n_bad++;
        $display("FAIL repress t=%0d got %h want %h", t, {lvl, prs, rel, rpt}, exp);
      end
      if (t == 31) key_in[1] = 1'b0;
    end
  endtask

  // Active-low pin pulled low during reset: level 0 in reset, press CNT_MAX+2 edges after release.
  task automatic test_active_low();
    logic [15:0] exp;
    rst = 1'b1;
    key_in_al[3] = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      step();
      n_cmp++;
      if ({lvl_al, prs_al} !== 8'h0) begin
        n_bad++;
        $display("FAIL al_in_reset t=%0d got %h want 00", t, {lvl_al, prs_al});
      end
    end
    rst = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      step();
      exp = {((t >= 10) ? 4'b1000 : 4'b0000),
             ((t == 10) ? 4'b1000 : 4'b0000),
             8'h00};
      n_cmp++;
      if ({lvl_al, prs_al, rel_al, rpt_al} !== exp) begin
        n_bad++;
        $display("FAIL active_low t=%0d got %h want %h", t, {lvl_al, prs_al, rel_al, rpt_al}, exp);
      end
    end
    key_in_al = 4'hF;
    repeat (15) step();
  endtask

  // Reset while keys 0/2 are repeating (repeat pulse high at t=35); both re-press at t=10 after.
  task automatic test_reset_mid();
    logic [15:0] exp;
    key_in = 4'b0101;
    for (int t = 1; t <= 35; t++) begin
      step();
      if (t == 10 || t == 30 || t == 35) begin
        exp = {4'b0101, ((t == 10) ? 4'b0101 : 4'b0000), 4'b0000,
               ((t >= 30) ? 4'b0101 : 4'b0000)};
        n_cmp++;
        if ({lvl, prs, rel, rpt} !== exp) begin
          n_bad++;
          $display("FAIL pre_reset t=%0d got %h want %h", t, {lvl, prs, rel, rpt}, exp);
        end
      end
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({lvl, prs, rel, rpt} !== 16'h0) begin
      n_bad++;
      $display("FAIL async_reset got %h want 0000", {lvl, prs, rel, rpt});
    end
    repeat (3) step();
    n_cmp++;
    if ({lvl, prs, rel, rpt} !== 16'h0) begin
      n_bad++;
      $display("FAIL held_reset got %h want 0000", {lvl, prs, rel, rpt});
    end
    rst = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      step();
      exp = {((t >= 10) ? 4'b0101 : 4'b0000),
             ((t == 10) ? 4'b0101 : 4'b0000),
             8'h00};
      n_cmp++;
      if ({lvl, prs, rel, rpt} !== exp) begin
        n_bad++;
        $display("FAIL post_reset t=%0d got %h want %h", t, {lvl, prs, rel, rpt}, exp);
      end
    end
    key_in = 4'h0;
    repeat (12) step();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_repeat();
    test_release_wins();
    test_active_low();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
